// File: rtl/sdc_loop_monitor.sv
// SDC loop read-back monitor: synchronises and debounces the end-of-loop sense and checks it
// against the relay close command. A close timeout or an uncommanded open latches a fault.
module sdc_loop_monitor #(
    parameter int DEBOUNCE_CYCLES      = 16,
    parameter int CLOSE_TIMEOUT_CYCLES = 50000,
    parameter int CNT_W                = 16
) (
    input  logic       clk,
    input  logic       power_on_reset,
    input  logic       sdc_sense,
    input  logic       sdc_close_cmd,
    input  logic       ebs_armed,
    input  logic       fault_clear,
    output logic       sdc_closed,
    output logic [1:0] sdc_state,
    output logic       ebs_trigger,
    output logic       close_timeout_err,
    output logic       unexpected_open_err
);

    typedef enum logic [1:0] {
        ST_OPEN    = 2'b00,
        ST_CLOSING = 2'b01,
        ST_CLOSED  = 2'b10,
        ST_FAULT   = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(CLOSE_TIMEOUT_CYCLES - 1);

    logic             sense_p0;
    logic             s_sync;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] timer;
    state_t           state;

    assign sdc_state = state;

    // Stage p0/p1: two-flop synchroniser for the asynchronous loop sense
    always_ff @(posedge clk or posedge power_on_reset) begin
        if (power_on_reset) begin
            sense_p0 <= 1'b0;
            s_sync   <= 1'b0;
        end else begin
            sense_p0 <= sdc_sense;
            s_sync   <= sense_p0;
        end
    end

    // Debounce: sdc_closed follows s_sync only after it has differed for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk or posedge power_on_reset) begin
        if (power_on_reset) begin
            deb_cnt    <= '0;
            sdc_closed <= 1'b0;
        end else if (s_sync == sdc_closed) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            sdc_closed <= s_sync;
            deb_cnt    <= '0;
        end else begin
            deb_cnt <= deb_cnt + CNT_W'(1);
        end
    end

    // Supervision FSM; ebs_trigger and error flags are registered alongside the state
    always_ff @(posedge clk or posedge power_on_reset) begin
        if (power_on_reset) begin
            state               <= ST_OPEN;
            timer               <= '0;
            ebs_trigger         <= 1'b0;
            close_timeout_err   <= 1'b0;
            unexpected_open_err <= 1'b0;
        end else begin
            case (state)
                ST_OPEN: begin
                    if (sdc_close_cmd) begin
                        state <= ST_CLOSING;
                        timer <= '0;
                    end
                end
                ST_CLOSING: begin
                    timer <= timer + CNT_W'(1);
                    // A loop that closes on the timeout cycle still counts as closed
                    if (sdc_closed) begin
                        state <= ST_CLOSED;
                    end else if (!sdc_close_cmd) begin
                        state <= ST_OPEN;
                    end else if (timer == TO_LAST) begin
                        state             <= ST_FAULT;
                        close_timeout_err <= 1'b1;
                        ebs_trigger       <= ebs_armed;
                    end
                end
                ST_CLOSED: begin
                    if (!sdc_closed) begin
                        if (sdc_close_cmd) begin
                            state               <= ST_FAULT;
                            unexpected_open_err <= 1'b1;
                            ebs_trigger         <= ebs_armed;
                        end else begin
                            state <= ST_OPEN;
                        end
                    end
                end
                ST_FAULT: begin
                    // Leaving FAULT needs the relay command dropped, so a clear cannot re-arm a live close
                    if (fault_clear && !sdc_close_cmd) begin
                        state               <= ST_OPEN;
                        ebs_trigger         <= 1'b0;
                        close_timeout_err   <= 1'b0;
                        unexpected_open_err <= 1'b0;
                    end else if (ebs_armed) begin
                        ebs_trigger <= 1'b1;
                    end
                end
                default: state <= ST_OPEN;
            endcase
        end
    end

endmodule

// File: tb/tb_sdc_loop_monitor.sv
// Self-checking bench for sdc_loop_monitor: directed scenarios plus a randomized run,
// all compared against a behavioural model of the loop monitor kept in the bench.
module tb_sdc_loop_monitor;

    localparam int DEB = 16;
    localparam int TO  = 100;

    localparam int S_OPEN    = 0;
    localparam int S_CLOSING = 1;
    localparam int S_CLOSED  = 2;
    localparam int S_FAULT   = 3;

    logic       clk = 1'b0;
    logic       power_on_reset = 1'b1;
    logic       sdc_sense = 1'b0;
    logic       sdc_close_cmd = 1'b0;
    logic       ebs_armed = 1'b0;
    logic       fault_clear = 1'b0;
    logic       sdc_closed;
    logic [1:0] sdc_state;
    logic       ebs_trigger;
    logic       close_timeout_err;
    logic       unexpected_open_err;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    bit m_d1, m_d2;          // sense sampled one and two edges ago
    bit win[$];              // last DEB synchronised samples seen by the debouncer
    bit m_closed;
    int m_state;
    int m_closing_cycles;
    bit m_trig, m_to, m_uo;

    sdc_loop_monitor #(
        .DEBOUNCE_CYCLES(DEB),
        .CLOSE_TIMEOUT_CYCLES(TO),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .power_on_reset(power_on_reset),
        .sdc_sense(sdc_sense),
        .sdc_close_cmd(sdc_close_cmd),
        .ebs_armed(ebs_armed),
        .fault_clear(fault_clear),
        .sdc_closed(sdc_closed),
        .sdc_state(sdc_state),
        .ebs_trigger(ebs_trigger),
        .close_timeout_err(close_timeout_err),
        .unexpected_open_err(unexpected_open_err)
    );

    always #5 clk = ~clk;

    wire [5:0] dut_vec = {sdc_closed, sdc_state, ebs_trigger, close_timeout_err, unexpected_open_err};

    function automatic logic [5:0] exp_vec();
        return {m_closed, 2'(m_state), m_trig, m_to, m_uo};
    endfunction

    task automatic model_reset();
        m_d1 = 0; m_d2 = 0; win.delete();
        m_closed = 0; m_state = S_OPEN; m_closing_cycles = 0;
        m_trig = 0; m_to = 0; m_uo = 0;
    endtask

    // One clock edge of the reference behaviour, using pre-edge inputs and state
    task automatic model_edge();
        bit s_pre, all_diff, nclosed;
        s_pre = m_d2;
        win.push_back(s_pre);
        if (win.size() > DEB) void'(win.pop_front());
        all_diff = (win.size() == DEB);
        foreach (win[i]) if (win[i] == m_closed) all_diff = 0;
        nclosed = all_diff ? s_pre : m_closed;

        case (m_state)
            S_OPEN: if (sdc_close_cmd) begin m_state = S_CLOSING; m_closing_cycles = 0; end
            S_CLOSING: begin
                m_closing_cycles++;
                if (m_closed) m_state = S_CLOSED;
                else if (!sdc_close_cmd) m_state = S_OPEN;
                else if (m_closing_cycles == TO) begin
                    m_state = S_FAULT; m_to = 1; m_trig = ebs_armed;
                end
            end
            S_CLOSED: if (!m_closed) begin
                if (sdc_close_cmd) begin m_state = S_FAULT; m_uo = 1; m_trig = ebs_armed; end
                else m_state = S_OPEN;
            end
            default: begin
                if (fault_clear && !sdc_close_cmd) begin
                    m_state = S_OPEN; m_trig = 0; m_to = 0; m_uo = 0;
                end else if (ebs_armed) m_trig = 1;
            end
        endcase

        m_closed = nclosed;
        m_d2 = m_d1;
        m_d1 = sdc_sense;
    endtask

    task automatic step();
        @(posedge clk);
        if (power_on_reset) model_reset(); else model_edge();
        #1;
    endtask

    task automatic test_reset();
        power_on_reset = 1'b1;
        model_reset();
        repeat (3) step();
        total++;
        if (dut_vec !== 6'b0) begin bad++; $display("FAIL reset_hold got=%b want=%b", dut_vec, 6'b0); end
        #3 power_on_reset = 1'b0;
        repeat (2) step();
        total++;
        if (dut_vec !== exp_vec()) begin bad++; $display("FAIL reset_release got=%b want=%b", dut_vec, exp_vec()); end
    endtask

    task automatic test_normal_close();
        int n;
        sdc_close_cmd = 1'b1;
        repeat (5) step();
        total++;
        if (dut_vec !== exp_vec() || sdc_state !== 2'b01) begin
            bad++; $display("FAIL t1_closing got=%b want=%b", dut_vec, exp_vec());
        end
        sdc_sense = 1'b1;
        n = 0;
        while (n < 40 && sdc_closed !== 1'b1) begin step(); n++; end
        total++;
        if (n != DEB + 2) begin bad++; $display("FAIL t1_latency got=%0d want=%0d", n, DEB + 2); end
        total++;
        if (dut_vec !== exp_vec() || sdc_state !== 2'b01) begin
            bad++; $display("FAIL t1_state_before got=%b want=%b", dut_vec, exp_vec());
        end
        step();
        total++;
        if (dut_vec !== exp_vec() || dut_vec !== 6'b110000) begin
            bad++; $display("FAIL t1_closed got=%b want=%b", dut_vec, 6'b110000);
        end
    endtask

    task automatic test_glitch();
        int errs = 0;
        sdc_sense = 1'b0;
        repeat (10) step();
        sdc_sense = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (dut_vec !== exp_vec() || dut_vec !== 6'b110000) errs++;
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL t2_glitch got=%b want=%b bad_cycles=%0d", dut_vec, 6'b110000, errs); end
    endtask

    task automatic test_uncommanded_open();
        int n = 0;
        ebs_armed = 1'b0;
        sdc_sense = 1'b0;
        while (n < 60 && sdc_state !== 2'b11) begin step(); n++; end
        total++;
        if (dut_vec !== exp_vec() || dut_vec !== 6'b011001) begin
            bad++; $display("FAIL t4_fault got=%b want=%b cycles=%0d", dut_vec, 6'b011001, n);
        end
        ebs_armed = 1'b1;
        step();
        total++;
        if (dut_vec !== exp_vec() || ebs_trigger !== 1'b1) begin
            bad++; $display("FAIL t4_armed_late got=%b want=%b", dut_vec, exp_vec());
        end
        ebs_armed = 1'b0;
        step();
        total++;
        if (dut_vec !== exp_vec() || ebs_trigger !== 1'b1) begin
            bad++; $display("FAIL t4_trigger_held got=%b want=%b", dut_vec, exp_vec());
        end
    endtask

    task automatic test_clear_rules();
        fault_clear = 1'b1;
        step();
        fault_clear = 1'b0;
        total++;
        if (dut_vec !== exp_vec() || sdc_state !== 2'b11) begin
            bad++; $display("FAIL t5_clear_ignored got=%b want=%b", dut_vec, exp_vec());
        end
        sdc_close_cmd = 1'b0;
        fault_clear = 1'b1;
        step();
        fault_clear = 1'b0;
        total++;
        if (dut_vec !== exp_vec() || dut_vec !== 6'b0) begin
            bad++; $display("FAIL t5_clear got=%b want=%b", dut_vec, 6'b0);
        end
    endtask

    task automatic test_timeout();
        ebs_armed = 1'b1;
        sdc_close_cmd = 1'b1;
        step();
        repeat (TO - 1) step();
        total++;
        if (dut_vec !== exp_vec() || sdc_state !== 2'b01) begin
            bad++; $display("FAIL t3_pre_timeout got=%b want=%b", dut_vec, exp_vec());
        end
        step();
        total++;
        if (dut_vec !== exp_vec() || dut_vec !== 6'b011110) begin
            bad++; $display("FAIL t3_timeout got=%b want=%b", dut_vec, 6'b011110);
        end
        sdc_close_cmd = 1'b0;
        fault_clear = 1'b1;
        step();
        fault_clear = 1'b0;
        ebs_armed = 1'b0;
        total++;
        if (dut_vec !== exp_vec() || dut_vec !== 6'b0) begin
            bad++; $display("FAIL t3_clear got=%b want=%b", dut_vec, 6'b0);
        end
    endtask

    task automatic test_reset_mid();
        sdc_close_cmd = 1'b1;
        ebs_armed = 1'b1;
        repeat (3) step();
        total++;
        if (dut_vec !== exp_vec() || sdc_state !== 2'b01) begin
            bad++; $display("FAIL t6_closing got=%b want=%b", dut_vec, exp_vec());
        end
        #2 power_on_reset = 1'b1;
        model_reset();
        #1;
        total++;
        if (dut_vec !== 6'b0) begin bad++; $display("FAIL t6_async_reset got=%b want=%b", dut_vec, 6'b0); end
        sdc_close_cmd = 1'b0;
        ebs_armed = 1'b0;
        repeat (2) step();
        #3 power_on_reset = 1'b0;
        step();
        total++;
        if (dut_vec !== exp_vec()) begin bad++; $display("FAIL t6_after_reset got=%b want=%b", dut_vec, exp_vec()); end
    endtask

    task automatic test_race();
        sdc_close_cmd = 1'b1;
        step();
        repeat (TO - DEB - 3) step();
        sdc_sense = 1'b1;
        repeat (DEB + 2) step();
        total++;
        if (dut_vec !== exp_vec() || dut_vec !== 6'b101000) begin
            bad++; $display("FAIL t6_race_pre got=%b want=%b", dut_vec, 6'b101000);
        end
        step();
        total++;
        if (dut_vec !== exp_vec() || dut_vec !== 6'b110000) begin
            bad++; $display("FAIL t6_race got=%b want=%b", dut_vec, 6'b110000);
        end
    endtask

    task automatic test_random();
        int shown = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) sdc_sense = ~sdc_sense;
            if ($urandom_range(0, 149) == 0) sdc_close_cmd = ~sdc_close_cmd;
            if ($urandom_range(0, 119) == 0) ebs_armed = ~ebs_armed;
            fault_clear = ($urandom_range(0, 49) == 0);
            step();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random cycle=%0d got=%b want=%b", i, dut_vec, exp_vec());
                end
            end
        end
        fault_clear = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_normal_close();
        test_glitch();
        test_uncommanded_open();
        test_clear_rules();
        test_timeout();
        test_reset_mid();
        test_race();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
